// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: state encodings, default width,
// and the SW/LEDR field offsets of the board wiring.
package seq_divider_pkg;

    localparam int W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int SW_DVD_LSB    = 0;
    localparam int SW_DVS_LSB    = 4;
    localparam int LEDR_QUO_LSB  = 0;
    localparam int LEDR_REM_LSB  = 4;
    localparam int LEDR_BUSY_BIT = 8;
    localparam int LEDR_DONE_BIT = 9;

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bundle of the trial subtractor (N-bit minuend, subtrahend, difference, no-borrow).
// Purely combinational; no handshake, the consumer samples whenever it needs the result.
interface seq_divider_if #(
    parameter int N = 5
);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] diff;
    logic         no_borrow;

    modport master (output a, output b, input diff, input no_borrow);
    modport slave  (input a, input b, output diff, output no_borrow);
endinterface

// File: rtl/seq_divider_sub_ripple.sv
// Ripple subtractor a - b as a chain of full adders fed with ~b and carry-in 1.
// Zero latency; no_borrow is the final carry-out, i.e. a >= b unsigned.
module sub_ripple #(
    parameter int N = 5
) (
    seq_divider_if.slave s
);
    logic [N-1:0] diff_v;
    logic         carry;

    always_comb begin
        diff_v = '0;
        carry  = 1'b1;
        for (int i = 0; i < N; i++) begin
            diff_v[i] = s.a[i] ^ ~s.b[i] ^ carry;
            carry     = (s.a[i] & ~s.b[i]) | (s.a[i] & carry) | (~s.b[i] & carry);
        end
    end

    assign s.diff      = diff_v;
    assign s.no_borrow = carry;

endmodule

// File: rtl/seq_divider.sv
// Restoring divider for the DE board: SW operands, KEY[1] start, LEDR result/status; done W+2 cycles
// after the press pulse, presses during LOAD/RUN ignored. DIV_DBZ_DETECT_EN adds a divide-by-zero fast path.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int W           = W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLOCK_50,
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic rst_n;
    assign rst_n = KEY[0];

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   key_prev_q, key_prev_d;
    logic                   press;

    state_e         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   d_q, d_d;
    logic [W:0]     r_q, r_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] result_q, result_d;
    logic           err_q, err_d;
    logic           busy;

    logic [W-1:0] sw_dvd;
    logic [W-1:0] sw_dvs;
    logic [W:0]   r_shift;
    logic         unused_bits;

    assign sw_dvd      = SW[SW_DVD_LSB +: W];
    assign sw_dvs      = SW[SW_DVS_LSB +: W];
    assign unused_bits = ^{SW[9:8], r_q[W]};

    seq_divider_if #(.N(W + 1)) sub_bus ();
    sub_ripple #(.N(W + 1)) u_sub (.s(sub_bus.slave));

    assign r_shift   = {r_q[W-1:0], q_q[W-1]};
    assign sub_bus.a = r_shift;
    assign sub_bus.b = {1'b0, d_q};

    // Button idles high; only a synchronized high-to-low edge starts an operation.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], KEY[1]};
        key_prev_d = sync_q[SYNC_STAGES-1];
        press      = key_prev_q & ~sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        d_d      = d_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (press) state_d = LOAD;
            end
            LOAD: begin
                q_d     = sw_dvd;
                d_d     = sw_dvs;
                r_d     = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = RUN;
`ifdef DIV_DBZ_DETECT_EN
                if (sw_dvs == '0) begin
                    err_d    = 1'b1;
                    result_d = {sw_dvd, {W{1'b1}}};
                    state_d  = DONE;
                end
`endif
            end
            RUN: begin
                r_d   = sub_bus.no_borrow ? sub_bus.diff : r_shift;
                q_d   = {q_q[W-2:0], sub_bus.no_borrow};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    result_d = {r_d[W-1:0], q_d};
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (press) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            key_prev_q <= 1'b1;
            state_q    <= IDLE;
            q_q        <= '0;
            d_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            key_prev_q <= key_prev_d;
            state_q    <= state_d;
            q_q        <= q_d;
            d_q        <= d_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            err_q      <= err_d;
        end
    end

    assign busy = (state_q == LOAD) || (state_q == RUN);

    always_comb begin
        LEDR                         = '0;
        LEDR[LEDR_QUO_LSB +: W]      = result_q[W-1:0];
        LEDR[LEDR_REM_LSB +: W]      = result_q[2*W-1:W];
        LEDR[LEDR_BUSY_BIT]          = busy | err_q;
        LEDR[LEDR_DONE_BIT]          = (state_q == DONE);
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: timeline model of press/load/run/done plus directed board scenarios and random KEY/SW traffic.
module tb_seq_divider;
    localparam int W = 4;
`ifdef DIV_DBZ_DETECT_EN
    localparam bit DBZ = 1'b1;
`else
    localparam bit DBZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       key0 = 1'b1;
    logic       key1 = 1'b1;
    logic [9:0] sw = '0;
    logic [9:0] ledr;

    int total = 0;
    int bad   = 0;

    seq_divider u_dut (
        .CLOCK_50(clk),
        .KEY     ({key1, key0}),
        .SW      (sw),
        .LEDR    (ledr)
    );

    seq_divider_if #(.N(5)) tb_sub ();
    sub_ripple #(.N(5)) u_sub (.s(tb_sub.slave));

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_div(input logic [3:0] dvd, input logic [3:0] dvs);
        if (dvs == 0) return {dvd, 4'hF};
        return {4'(dvd % dvs), 4'(dvd / dvs)};
    endfunction

    // Model: phase counts cycles since the press pulse (0 = idle or done).
    int         phase  = 0;
    bit         m_done = 0;
    bit         m_err  = 0;
    logic [7:0] m_last = '0;
    logic [7:0] m_pend = '0;
    bit         h1 = 1, h2 = 1, m_pulse = 0;

    always @(posedge clk or negedge key0) begin
        if (!key0) begin
            phase = 0; m_done = 0; m_err = 0; m_last = '0;
            h1 = 1; h2 = 1; m_pulse = 0;
        end else begin
            if (phase == 0) begin
                if (m_pulse) begin phase = 1; m_done = 0; m_err = 0; end
            end else if (phase == 1) begin
                m_pend = model_div(sw[3:0], sw[7:4]);
                if (DBZ && sw[7:4] == 0) begin
                    phase = 0; m_done = 1; m_err = 1; m_last = m_pend;
                end else phase = 2;
            end else if (phase < W + 1) begin
                phase++;
            end else begin
                phase = 0; m_done = 1; m_last = m_pend;
            end
            m_pulse = h2 && !h1;
            h2 = h1;
            h1 = key1;
        end
    end

    always @(negedge clk)
        chk("ledr_model", ledr, {m_done, (phase != 0) || m_err, m_last});

    int done_rises = 0;
    bit done_prev  = 0;
    always @(negedge clk) begin
        if (ledr[9] && !done_prev) done_rises++;
        done_prev = ledr[9];
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic run_op(input logic [3:0] dvd, input logic [3:0] dvs,
                          input logic [3:0] eq, input logic [3:0] er, input string nm);
        logic [7:0] old;
        int lat;
        int exp_lat;
        bit dz;
        dz = DBZ && dvs == 0;
        exp_lat = dz ? 4 : W + 4;
        key1 = 1'b1;
        sw = {2'b00, dvs, dvd};
        tick(2);
        old = ledr[7:0];
        key1 = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (i == 3) begin
                chk({nm, "_c1_busy"}, ledr[8], 1);
                chk({nm, "_c1_hold"}, ledr[7:0], old);
            end
            if (i == 4) key1 = 1'b1;
            if (i >= 3 && ledr[9]) begin lat = i; break; end
        end
        key1 = 1'b1;
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_result"}, ledr, {1'b1, dz, er, eq});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        #1 key0 = 1'b0;
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                tb_sub.a = 5'(a);
                tb_sub.b = 5'(b);
                #1;
                chk("sub_ripple", {tb_sub.no_borrow, tb_sub.diff}, {a >= b, 5'(a - b)});
            end
        end
        chk("reset_ledr", ledr, 0);
        @(posedge clk); #2 key0 = 1'b1;
        tick(3);

        run_op(13, 3, 4, 1, "t1_13_3");
        chk("t1_literal", ledr, 10'h214);
        run_op(15, 15, 1, 0, "t2_15_15");
        run_op(2, 7, 0, 2, "t2_2_7");
        run_op(5, 0, 15, 5, "t3_5_0");
        chk("t3_literal", ledr, DBZ ? 10'h35F : 10'h25F);
        run_op(3, 9, 0, 3, "t_lt");

        // Second press and SW change while running must not disturb 9/2.
        key1 = 1'b1; sw = {2'b00, 4'd2, 4'd9}; tick(2);
        r0 = done_rises;
        key1 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (i == 4) begin key1 = 1'b1; sw = {2'b00, 4'd1, 4'd1}; end
            if (i == 5) key1 = 1'b0;
        end
        chk("t4_result", ledr, 10'h214);
        key1 = 1'b1;
        tick(20);
        chk("t4_one_done", done_rises - r0, 1);
        chk("t4_hold", ledr, 10'h214);

        // Reset in RUN cycle 3.
        key1 = 1'b1; sw = {2'b00, 4'd3, 4'd13}; tick(2);
        key1 = 1'b0;
        tick(5);
        key0 = 1'b0;
        #1 chk("t5_reset_now", ledr, 0);
        key1 = 1'b1;
        tick(2);
        key0 = 1'b1;
        tick(3);
        chk("t5_idle", ledr, 0);
        run_op(12, 5, 2, 2, "t5_12_5");

        // Long hold then release.
        key1 = 1'b1; sw = {2'b00, 4'd4, 4'd11}; tick(2);
        r0 = done_rises;
        key1 = 1'b0;
        tick(50);
        chk("t6_one_op", done_rises - r0, 1);
        chk("t6_result", ledr, {2'b10, 4'd3, 4'd2});
        key1 = 1'b1;
        tick(20);
        chk("t6_release", done_rises - r0, 1);

        for (int n = 0; n < 3000; n++) begin
            tick(1);
            if (!key0) key0 = 1'b1;
            else if ($urandom_range(0, 399) == 0) key0 = 1'b0;
            if ($urandom_range(0, 99) < 6) key1 = ~key1;
            if ($urandom_range(0, 99) < 10) sw = 10'($urandom);
        end
        key0 = 1'b1;
        key1 = 1'b1;
        tick(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Board-level sequential restoring divider for DE-series labs; the arithmetic inverse of the switch-driven ripple adder.
- Takes a 4-bit dividend and a 4-bit divisor from SW.
- Computes quotient and remainder over W cycles using trial subtraction.
- Shows the results and status on LEDR.
- Start comes from a pushbutton; one clock domain throughout.

Parameters:
W, 4, operand width; the top-level SW/LEDR bit map is defined for W=4 only; the sub-module is generic in W.
SYNC_STAGES, 2, flip-flop depth of the KEY[1] synchronizer.

Ports:
CLOCK_50  input  1  system clock; all state is updated on its rising edge.
KEY  input  2  KEY[0]: reset, asynchronous, active-low. KEY[1]: start pushbutton, active-low, asynchronous to CLOCK_50.
SW  input  10  SW[3:0]: dividend. SW[7:4]: divisor. SW[9:8]: unused.
LEDR  output  10  LEDR[3:0]: quotient. LEDR[7:4]: remainder. LEDR[8]: busy. LEDR[9]: done.

Behaviour:
- Reset (KEY[0]=0, asynchronous):
  - State goes to IDLE; all LEDR bits are 0; synchronizer flops are 1 (button released).
  - Reset is honoured in any state. Mid-RUN, the in-flight result is discarded.
- Start:
  - KEY[1] passes through SYNC_STAGES flops.
  - A 1-cycle press pulse is generated on the synchronized 1->0 transition.
  - Holding the button produces only one pulse.
- State machine: IDLE, LOAD, RUN, DONE.
  - IDLE: on press, go to LOAD.
  - LOAD: capture dividend into shift register Q and divisor into D; clear partial remainder R (W+1 bits) and step counter; go to RUN.
  - RUN, one step per cycle:
    - R' = {R[W-1:0], Q[W-1]}.
    - If R' >= D: R = R' - D and shift 1 into Q. Otherwise R = R' and shift 0 into Q.
    - After the W-th step (counter == W-1), go to DONE.
  - DONE: on press, go to LOAD (restart with current SW). Otherwise hold.
- Latency:
  - Call the cycle in which the press pulse is high cycle 0.
  - LOAD is cycle 1; RUN is cycles 2..W+1; DONE is entered at cycle W+2.
  - For W=4, done rises 6 cycles after the pulse.
- Outputs:
  - LEDR[7:0] is a result register, loaded with {R[W-1:0], Q} on entry to DONE.
  - It holds the last completed result during IDLE, LOAD and RUN (0 after reset).
  - busy (LEDR[8]) is 1 in LOAD and RUN, 0 otherwise.
  - done (LEDR[9]) is 1 only in DONE.
- Boundaries:
  - A press during LOAD or RUN is ignored.
  - SW changes after LOAD do not affect the running operation.
  - Divisor 0 falls out of the algorithm: quotient = all ones, remainder = dividend, full W-step latency.
  - Dividend < divisor gives quotient 0, remainder = dividend.
  - The comparison uses the W+1-bit borrow of the subtractor, never a truncated compare.

Optional Feature:
Macro DIV_DBZ_DETECT_EN.
- Defined:
  - LOAD checks for divisor == 0. If so, it skips RUN, goes directly to DONE (done at cycle 2), and loads quotient = all ones, remainder = dividend.
  - LEDR[8] is 1 while in DONE after a divide-by-zero, acting as an error lamp instead of busy. It clears on the next LOAD or reset.
- Undefined:
  - No detection; divisor 0 takes the normal W-step path.
  - LEDR[8] is busy only.

Decomposition:
- Shared include file div_defs.vh:
  - state encodings IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3;
  - default W;
  - the SW/LEDR field offsets.
- Sub-module sub_ripple: combinational W+1-bit subtractor.
  - Built as a chain of full-adder cells with inverted B and carry-in 1.
  - Outputs the difference and no_borrow (final carry-out = R' >= D).
- The FSM, datapath registers and synchronizer live in seq_divider.

Test Plan:
1. SW[3:0]=13, SW[7:4]=3, press KEY[1] -> busy high cycles 1-5; at cycle 6 done=1, LEDR[3:0]=4, LEDR[7:4]=1.
2. 15/15 -> quotient 1, remainder 0. Then 2/7 via a second press from DONE -> quotient 0, remainder 2; LEDR holds 0x01 until the new DONE.
3. 5/0, macro undefined -> done at cycle 6, quotient 15, remainder 5, LEDR[8]=0 in DONE. Macro defined -> done at cycle 2, quotient 15, remainder 5, LEDR[8]=1 in DONE.
4. Press 9/2; toggle SW to 1/1 and press again during RUN -> result still quotient 4, remainder 1; exactly one done entry.
5. Assert KEY[0]=0 during RUN cycle 3 -> LEDR=0 immediately and IDLE. After release, a press with 12/5 -> quotient 2, remainder 2 at cycle 6.
6. Hold KEY[1] low for 50 cycles -> exactly one operation. Glitch-free release generates no pulse.
